// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes RV32I fields into an ALU select, picks operands, and
// registers them behind a valid/ready output with a one-entry skid. ALU_ISSUE_PERF_EN adds issue/stall counters.
module alu_issue_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_opcode,
    input  logic [2:0]            i_funct3,
    input  logic                  i_funct7b5,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [DATA_WIDTH-1:0] i_imm,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_flush,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_src_a,
    output logic [DATA_WIDTH-1:0] o_src_b,
    output logic [SEL_WIDTH-1:0]  o_sel,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]           o_issue_cnt,
    output logic [31:0]           o_stall_cnt,
`endif
    output logic                  o_illegal
);

    localparam logic [SEL_WIDTH-1:0] SEL_ADD  = SEL_WIDTH'(0);
    localparam logic [SEL_WIDTH-1:0] SEL_SUB  = SEL_WIDTH'(1);
    localparam logic [SEL_WIDTH-1:0] SEL_SLL  = SEL_WIDTH'(2);
    localparam logic [SEL_WIDTH-1:0] SEL_SLT  = SEL_WIDTH'(3);
    localparam logic [SEL_WIDTH-1:0] SEL_SLTU = SEL_WIDTH'(4);
    localparam logic [SEL_WIDTH-1:0] SEL_XOR  = SEL_WIDTH'(5);
    localparam logic [SEL_WIDTH-1:0] SEL_SRL  = SEL_WIDTH'(6);
    localparam logic [SEL_WIDTH-1:0] SEL_SRA  = SEL_WIDTH'(7);
    localparam logic [SEL_WIDTH-1:0] SEL_OR   = SEL_WIDTH'(8);
    localparam logic [SEL_WIDTH-1:0] SEL_AND  = SEL_WIDTH'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Register-register ops honour funct7b5 for SUB; immediates only for SRAI.
    function automatic logic [SEL_WIDTH-1:0] alu_map(input logic [2:0] f3, input logic f7b5,
                                                     input logic is_reg);
        case (f3)
            3'b000:  alu_map = (is_reg && f7b5) ? SEL_SUB : SEL_ADD;
            3'b001:  alu_map = SEL_SLL;
            3'b010:  alu_map = SEL_SLT;
            3'b011:  alu_map = SEL_SLTU;
            3'b100:  alu_map = SEL_XOR;
            3'b101:  alu_map = f7b5 ? SEL_SRA : SEL_SRL;
            3'b110:  alu_map = SEL_OR;
            default: alu_map = SEL_AND;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] dec_a, dec_b;
    logic [SEL_WIDTH-1:0]  dec_sel;
    logic                  dec_ill;

    always_comb begin
        dec_a   = i_rs1_data;
        dec_b   = i_rs2_data;
        dec_sel = SEL_ADD;
        dec_ill = 1'b0;
        case (i_opcode)
            OPC_OP:     dec_sel = alu_map(i_funct3, i_funct7b5, 1'b1);
            OPC_OP_IMM: begin
                dec_b   = i_imm;
                dec_sel = alu_map(i_funct3, i_funct7b5, 1'b0);
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = i_imm;
            end
            OPC_AUIPC: begin
                dec_a = i_pc;
                dec_b = i_imm;
            end
            OPC_LOAD, OPC_STORE: dec_b = i_imm;
            OPC_BRANCH: begin
                case (i_funct3)
                    3'b000, 3'b001: dec_sel = SEL_SUB;
                    3'b100, 3'b101: dec_sel = SEL_SLT;
                    3'b110, 3'b111: dec_sel = SEL_SLTU;
                    default:        dec_ill = 1'b1;
                endcase
            end
            OPC_JAL, OPC_JALR: begin
                dec_a = i_pc;
                dec_b = DATA_WIDTH'(4);
            end
            default: dec_ill = 1'b1;
        endcase
        // The ALU shifts by the whole B value, so the amount must arrive pre-masked.
        if (dec_sel == SEL_SLL || dec_sel == SEL_SRL || dec_sel == SEL_SRA)
            dec_b = {{(DATA_WIDTH-5){1'b0}}, dec_b[4:0]};
    end

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic [SEL_WIDTH-1:0]  out_sel_q, out_sel_d;
    logic                  out_ill_q, out_ill_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [SEL_WIDTH-1:0]  skid_sel_q, skid_sel_d;
    logic                  skid_ill_q, skid_ill_d;
    logic                  in_fire, out_fire;

    assign o_ready  = !skid_valid_q;
    assign in_fire  = i_valid && o_ready;
    assign out_fire = out_valid_q && i_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_a_d      = out_a_q;
        out_b_d      = out_b_q;
        out_sel_d    = out_sel_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_a_d     = skid_a_q;
        skid_b_d     = skid_b_q;
        skid_sel_d   = skid_sel_q;
        skid_ill_d   = skid_ill_q;
        if (i_flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            // Skid full implies o_ready low, so it never competes with a new input.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_a_d      = skid_a_q;
                out_b_d      = skid_b_q;
                out_sel_d    = skid_sel_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_a_d     = dec_a;
                out_b_d     = dec_b;
                out_sel_d   = dec_sel;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_a_d     = dec_a;
            skid_b_d     = dec_b;
            skid_sel_d   = dec_sel;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_sel_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_a_q     <= '0;
            skid_b_q     <= '0;
            skid_sel_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_a_q      <= out_a_d;
            out_b_q      <= out_b_d;
            out_sel_q    <= out_sel_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_a_q     <= skid_a_d;
            skid_b_q     <= skid_b_d;
            skid_sel_q   <= skid_sel_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign o_valid   = out_valid_q;
    assign o_src_a   = out_a_q;
    assign o_src_b   = out_b_q;
    assign o_sel     = out_sel_q;
    assign o_illegal = out_ill_q;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (out_fire)
                issue_cnt_q <= issue_cnt_q + 32'd1;
            if (out_valid_q && !i_ready)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign o_issue_cnt = issue_cnt_q;
    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed ops push expected ALU requests,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic        ill;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [6:0]  i_opcode = '0;
    logic [2:0]  i_funct3 = '0;
    logic        i_funct7b5 = 1'b0;
    logic [31:0] i_rs1_data = '0, i_rs2_data = '0, i_imm = '0, i_pc = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_src_a, o_src_b;
    logic [3:0]  o_sel;
    logic        o_illegal;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 i_clk = ~i_clk;

    alu_issue_stage dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7b5(i_funct7b5),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm), .i_pc(i_pc),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_src_a(o_src_a), .o_src_b(o_src_b), .o_sel(o_sel), .o_illegal(o_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Transfer happens at the next posedge; inputs only change at posedge+1.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready && !i_flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_op: got a=0x%08h b=0x%08h sel=%0d, expected none",
                         o_src_a, o_src_b, o_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if ({o_src_a, o_src_b, o_sel, o_illegal} !== e) begin
                    errors++;
                    $display("FAIL op_compare: got a=0x%08h b=0x%08h sel=%0d ill=%0b, expected a=0x%08h b=0x%08h sel=%0d ill=%0b",
                             o_src_a, o_src_b, o_sel, o_illegal, e.a, e.b, e.sel, e.ill);
                end else begin
                    $display("op ok: a=0x%08h b=0x%08h sel=%0d ill=%0b", o_src_a, o_src_b, o_sel, o_illegal);
                end
            end
        end
    end

    task automatic send(input bit push, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [3:0] es, input logic eil);
        int n;
        i_opcode = op; i_funct3 = f3; i_funct7b5 = f7;
        i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm; i_pc = pc;
        i_valid = 1'b1;
        n = 0;
        while (!o_ready && n < 50) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got o_ready=0, expected 1 within 50 cycles");
        end
        if (push) exp_q.push_back('{a: ea, b: eb, sel: es, ill: eil});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk); #1;
        end
    endtask

    initial begin
        #2;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_ready", 32'(o_ready), 32'd1);
        check("reset_a", o_src_a, 32'd0);
        check("reset_b", o_src_b, 32'd0);
        check("reset_sel", 32'(o_sel), 32'd0);
        check("reset_ill", 32'(o_illegal), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_ready = 1'b1;

        // Latency: ADD presented now is on the output after one edge.
        i_opcode = 7'b0110011; i_funct3 = 3'b000; i_funct7b5 = 1'b0;
        i_rs1_data = 32'd5; i_rs2_data = 32'd7; i_valid = 1'b1;
        exp_q.push_back('{a: 32'd5, b: 32'd7, sel: 4'd0, ill: 1'b0});
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        check("latency_valid", 32'(o_valid), 32'd1);

        // Back-to-back directed table at full throughput.
        send(1, 7'b0010011, 3'b101, 1'b1, 32'h8000_0000, 32'h0, 32'h405, 32'h0, 32'h8000_0000, 32'd5, 4'd7, 1'b0);
        send(1, 7'b0110011, 3'b000, 1'b1, 32'd10, 32'd3, 32'h0, 32'h0, 32'd10, 32'd3, 4'd1, 1'b0);
        send(1, 7'b1100011, 3'b110, 1'b0, 32'd1, 32'd2, 32'h0, 32'h0, 32'd1, 32'd2, 4'd4, 1'b0);
        send(1, 7'b0010111, 3'b000, 1'b0, 32'd9, 32'd9, 32'h1000, 32'h100, 32'h100, 32'h1000, 4'd0, 1'b0);
        send(1, 7'b1111111, 3'b000, 1'b0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11, 32'h22, 4'd0, 1'b1);
        send(1, 7'b0110111, 3'b010, 1'b0, 32'h55, 32'h66, 32'h1234_5000, 32'h0, 32'h0, 32'h1234_5000, 4'd0, 1'b0);
        send(1, 7'b1101111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h800, 32'h200, 32'h200, 32'd4, 4'd0, 1'b0);
        send(1, 7'b1100111, 3'b000, 1'b0, 32'h55, 32'h66, 32'h8, 32'h300, 32'h300, 32'd4, 4'd0, 1'b0);
        send(1, 7'b0010011, 3'b000, 1'b1, 32'd3, 32'd0, 32'hFFFF_FFFF, 32'h0, 32'd3, 32'hFFFF_FFFF, 4'd0, 1'b0);
        send(1, 7'b0110011, 3'b001, 1'b0, 32'd1, 32'h25, 32'h0, 32'h0, 32'd1, 32'd5, 4'd2, 1'b0);
        send(1, 7'b0110011, 3'b101, 1'b0, 32'hF0, 32'hFFFF_FFE3, 32'h0, 32'h0, 32'hF0, 32'd3, 4'd6, 1'b0);
        send(1, 7'b1100011, 3'b010, 1'b0, 32'h7, 32'h8, 32'h0, 32'h0, 32'h7, 32'h8, 4'd0, 1'b1);
        send(1, 7'b1100011, 3'b000, 1'b0, 32'h7, 32'h8, 32'h0, 32'h0, 32'h7, 32'h8, 4'd1, 1'b0);
        send(1, 7'b1100011, 3'b101, 1'b0, 32'h7, 32'h8, 32'h0, 32'h0, 32'h7, 32'h8, 4'd3, 1'b0);
        send(1, 7'b0000011, 3'b010, 1'b0, 32'h1000, 32'h8, 32'h10, 32'h0, 32'h1000, 32'h10, 4'd0, 1'b0);
        send(1, 7'b0100011, 3'b010, 1'b0, 32'h2000, 32'h8, 32'hFFFF_FFFC, 32'h0, 32'h2000, 32'hFFFF_FFFC, 4'd0, 1'b0);
        send(1, 7'b0010011, 3'b100, 1'b0, 32'h1, 32'h0, 32'h2, 32'h0, 32'h1, 32'h2, 4'd5, 1'b0);
        send(1, 7'b0010011, 3'b110, 1'b0, 32'h1, 32'h0, 32'h2, 32'h0, 32'h1, 32'h2, 4'd8, 1'b0);
        send(1, 7'b0110011, 3'b111, 1'b0, 32'h1, 32'h3, 32'h0, 32'h0, 32'h1, 32'h3, 4'd9, 1'b0);
        send(1, 7'b0010011, 3'b011, 1'b0, 32'h1, 32'h0, 32'h9, 32'h0, 32'h1, 32'h9, 4'd4, 1'b0);
        idle(3);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Stall: two ops fill output + skid, third waits until release.
        i_ready = 1'b0;
        send(1, 7'b0110011, 3'b000, 1'b0, 32'd1, 32'd1, 32'h0, 32'h0, 32'd1, 32'd1, 4'd0, 1'b0);
        send(1, 7'b0110011, 3'b100, 1'b0, 32'd2, 32'd2, 32'h0, 32'h0, 32'd2, 32'd2, 4'd5, 1'b0);
        check("stall_ready_low", 32'(o_ready), 32'd0);
        check("stall_valid", 32'(o_valid), 32'd1);
        check("stall_hold_a", o_src_a, 32'd1);
        idle(2);
        check("stall_hold_a_later", o_src_a, 32'd1);
        check("stall_ready_still_low", 32'(o_ready), 32'd0);
        i_ready = 1'b1;
        send(1, 7'b0110011, 3'b110, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0, 32'd3, 32'd3, 4'd8, 1'b0);
        idle(3);
        check("stall_drain_empty", 32'(exp_q.size()), 32'd0);

        // Flush with output and skid full plus a new input: nothing survives.
        i_ready = 1'b0;
        send(0, 7'b0110011, 3'b000, 1'b0, 32'hA1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        send(0, 7'b0110011, 3'b000, 1'b0, 32'hA2, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        i_opcode = 7'b0110011; i_rs1_data = 32'hA3; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush_valid", 32'(o_valid), 32'd0);
        check("flush_ready", 32'(o_ready), 32'd1);
        // Flush with an empty skid and an input that would otherwise be accepted.
        send(0, 7'b0110011, 3'b000, 1'b0, 32'hB1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        i_opcode = 7'b0110011; i_rs1_data = 32'hB2; i_valid = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        check("flush2_valid", 32'(o_valid), 32'd0);
        check("flush2_ready", 32'(o_ready), 32'd1);
        i_ready = 1'b1;
        idle(4);
        send(1, 7'b0110011, 3'b000, 1'b1, 32'd20, 32'd6, 32'h0, 32'h0, 32'd20, 32'd6, 4'd1, 1'b0);
        idle(2);

        // Asynchronous reset mid-stream while ops are held.
        i_ready = 1'b0;
        send(0, 7'b0010111, 3'b000, 1'b0, 32'h0, 32'h0, 32'h44, 32'h88, 32'h0, 32'h0, 4'd0, 1'b0);
        send(0, 7'b1111111, 3'b000, 1'b0, 32'h9, 32'h9, 32'h0, 32'h0, 32'h0, 32'h0, 4'd0, 1'b0);
        #2 i_rst = 1'b1;
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_a", o_src_a, 32'd0);
        check("rst_b", o_src_b, 32'd0);
        check("rst_sel", 32'(o_sel), 32'd0);
        check("rst_ill", 32'(o_illegal), 32'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        i_ready = 1'b1;
        idle(3);
        send(1, 7'b0010011, 3'b001, 1'b0, 32'd1, 32'd0, 32'h3F, 32'h0, 32'd1, 32'd31, 4'd2, 1'b0);
        idle(3);
        check("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
